// File: rtl/s1238_bist_pkg.sv
// Shared types and constants for the s1238 cone BIST harness.
// Holds the FSM encoding, LFSR taps, signature defaults and the pattern-bus bit order.
package s1238_bist_pkg;

    localparam int N_IN  = 18;
    localparam int CNT_W = 16;
    localparam int SIG_W = 16;

    localparam logic [SIG_W-1:0] SIG_INIT = 16'hFFFF;
    localparam logic [SIG_W-1:0] POLY     = 16'h1021;

    localparam int LFSR_TAP_HI = 17;
    localparam int LFSR_TAP_LO = 10;

    // Cone input G-number driven by each pat_out bit, listed from bit 17 down to bit 0.
    localparam int PAT_ORDER [N_IN] = '{1, 3, 4, 10, 34, 13, 7, 9, 6, 8, 12, 11, 46, 5, 31, 0, 2, 30};

    typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

    function automatic logic [N_IN-1:0] lfsr_next(input logic [N_IN-1:0] s);
        return {s[N_IN-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/s1238_n117_bist_if.sv
// Control/observation bundle between the BIST harness and its host plus the cone under test.
// master drives start/abort/seed/num_patterns and plays the cone (resp_in); slave is the harness.
interface s1238_n117_bist_if;
    import s1238_bist_pkg::*;

    logic                 start;
    logic                 abort;
    logic [N_IN-1:0]      seed;
    logic [CNT_W-1:0]     num_patterns;
    logic [N_IN-1:0]      pat_out;
    logic                 resp_in;
    logic                 busy;
    logic                 done;
    logic [SIG_W-1:0]     signature;
    logic [CNT_W-1:0]     ones_count;

    modport master (
        output start, abort, seed, num_patterns, resp_in,
        input  pat_out, busy, done, signature, ones_count
    );

    modport slave (
        input  start, abort, seed, num_patterns, resp_in,
        output pat_out, busy, done, signature, ones_count
    );

endinterface

// File: rtl/s1238_sig_misr.sv
// Serial signature register: shifts one response bit per enabled cycle with polynomial feedback.
// init reloads the start value and wins over en.
module s1238_sig_misr #(
    parameter int           W    = 16,
    parameter logic [W-1:0] POLY = 16'h1021,
    parameter logic [W-1:0] INIT = 16'hFFFF
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         init,
    input  logic         en,
    input  logic         shift_in,
    output logic [W-1:0] sig
);

    logic fb;

    assign fb = sig[W-1] ^ shift_in;

    // NOTE: sequential state uses non-blocking assignments and an async reset in the sensitivity list.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            sig <= INIT;
        end else if (init) begin
            sig <= INIT;
        end else if (en) begin
            sig <= {sig[W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/s1238_n117_bist.sv
// BIST harness for the s1238 n117 cone: LFSR stimulus, 2 cycles per pattern, MISR compaction,
// saturating ones counter and a start/busy/done handshake with abort.
module s1238_n117_bist
    import s1238_bist_pkg::*;
(
    input  logic              CK,
    input  logic              RST,
    s1238_n117_bist_if.slave  bus
);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   lfsr_q;
    logic [N_IN-1:0]   pat_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  ones_q;
    logic              load_run;
    logic              apply_en;
    logic              capture_en;
    logic              busy;
    logic              done;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: if (bus.start) state_d = (bus.num_patterns == '0) ? DONE : APPLY;
                APPLY:      state_d = CAPTURE;
                CAPTURE:    state_d = (cnt_q == CNT_W'(1)) ? DONE : APPLY;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        load_run   = 1'b0;
        apply_en   = 1'b0;
        capture_en = 1'b0;
        unique case (state_q)
            IDLE:    load_run   = bus.start && !bus.abort;
            APPLY: begin
                busy     = 1'b1;
                apply_en = !bus.abort;
            end
            CAPTURE: begin
                busy       = 1'b1;
                capture_en = !bus.abort;
            end
            DONE: begin
                done     = 1'b1;
                load_run = bus.start && !bus.abort;
            end
            default: ;
        endcase
    end

    // A zero seed would lock the LFSR, so it is replaced by 1.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            lfsr_q <= N_IN'(1);
            pat_q  <= '0;
            cnt_q  <= '0;
            ones_q <= '0;
        end else begin
            if (load_run) begin
                lfsr_q <= (bus.seed == '0) ? N_IN'(1) : bus.seed;
                cnt_q  <= bus.num_patterns;
                ones_q <= '0;
            end
            if (apply_en) pat_q <= lfsr_q;
            if (capture_en) begin
                lfsr_q <= lfsr_next(lfsr_q);
                cnt_q  <= cnt_q - 1'b1;
                if (bus.resp_in && ones_q != '1) ones_q <= ones_q + 1'b1;
            end
        end
    end

    s1238_sig_misr #(
        .W    (SIG_W),
        .POLY (POLY),
        .INIT (SIG_INIT)
    ) u_misr (
        .CK       (CK),
        .RST      (RST),
        .init     (load_run),
        .en       (capture_en),
        .shift_in (bus.resp_in),
        .sig      (bus.signature)
    );

    assign bus.pat_out    = pat_q;
    assign bus.ones_count = ones_q;
    assign bus.busy       = busy;
    assign bus.done       = done;

endmodule
